// File: rtl/hazard_forward_unit_pkg.sv
// rtl/hazard_forward_unit_pkg.sv - forwarding-select encodings and stall FSM state type
package hazard_forward_unit_pkg;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b10;
  localparam fwd_sel_t FWD_WB  = 2'b01;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_STALL = 1'b1;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// rtl/hazard_forward_unit_if.sv - pipeline-to-hazard-unit bundle; stall_cnt exists only with HFU_STATS_EN
interface hazard_forward_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] ifid_rs;
  logic [REG_AW-1:0] ifid_rt;
  logic [REG_AW-1:0] idex_rs;
  logic [REG_AW-1:0] idex_rt;
  logic              idex_memread;
  logic [REG_AW-1:0] exmem_rd;
  logic [REG_AW-1:0] memwb_rd;
  logic              exmem_regwrite;
  logic              memwb_regwrite;
  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic              pc_write;
  logic              ifid_write;
  logic              idex_bubble;
`ifdef HFU_STATS_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  modport master (
    output ifid_rs, ifid_rt, idex_rs, idex_rt, idex_memread,
    output exmem_rd, memwb_rd, exmem_regwrite, memwb_regwrite,
`ifdef HFU_STATS_EN
    input  stall_cnt,
`endif
    input  forward_a, forward_b, pc_write, ifid_write, idex_bubble
  );

  modport slave (
    input  ifid_rs, ifid_rt, idex_rs, idex_rt, idex_memread,
    input  exmem_rd, memwb_rd, exmem_regwrite, memwb_regwrite,
`ifdef HFU_STATS_EN
    output stall_cnt,
`endif
    output forward_a, forward_b, pc_write, ifid_write, idex_bubble
  );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// rtl/hazard_forward_unit_fwd_select.sv - one ALU operand forwarding select; EX/MEM beats MEM/WB
module fwd_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic              memwb_regwrite_i,
  output fwd_sel_t          sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i)) begin
      sel_o = FWD_MEM;
    end else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - operand forwarding plus load-use stall FSM; HFU_STATS_EN adds stall_cnt
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  hazard_forward_unit_if.slave hfu
);

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .src_i            (hfu.idex_rs),
    .exmem_rd_i       (hfu.exmem_rd),
    .exmem_regwrite_i (hfu.exmem_regwrite),
    .memwb_rd_i       (hfu.memwb_rd),
    .memwb_regwrite_i (hfu.memwb_regwrite),
    .sel_o            (hfu.forward_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .src_i            (hfu.idex_rt),
    .exmem_rd_i       (hfu.exmem_rd),
    .exmem_regwrite_i (hfu.exmem_regwrite),
    .memwb_rd_i       (hfu.memwb_rd),
    .memwb_regwrite_i (hfu.memwb_regwrite),
    .sel_o            (hfu.forward_b)
  );

  logic   load_use;
  logic   bubble;
  logic   bubble_o;
  state_t state_q, state_d;
  logic [2:0] bcnt_q, bcnt_d;

  assign load_use = hfu.idex_memread && (hfu.idex_rt != '0) &&
                    ((hfu.idex_rt == hfu.ifid_rs) || (hfu.idex_rt == hfu.ifid_rt));

  // The first bubble is issued from IDLE; STALL covers the remaining LOAD_STALL-1 cycles.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    bubble  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_use) begin
          bubble = 1'b1;
          if (LOAD_STALL > 1) begin
            state_d = ST_STALL;
            bcnt_d  = 3'(LOAD_STALL - 1);
          end
        end
      end
      ST_STALL: begin
        bubble = 1'b1;
        bcnt_d = bcnt_q - 3'd1;
        if (bcnt_q == 3'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        bcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Reset masks the stall controls immediately, even if state_q still holds STALL.
  assign bubble_o        = bubble && !reset;
  assign hfu.idex_bubble = bubble_o;
  assign hfu.pc_write    = !bubble_o;
  assign hfu.ifid_write  = !bubble_o;

`ifdef HFU_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (bubble_o && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hfu.stall_cnt = stall_cnt_q;
`else
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - vector, sequence and random checks for LOAD_STALL=3 and LOAD_STALL=1 units
module tb_hazard_forward_unit;

  localparam int AW = 5;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_forward_unit_if #(.REG_AW(AW), .CNT_W(CW)) if3 ();
  hazard_forward_unit_if #(.REG_AW(AW), .CNT_W(CW)) if1 ();

  assign if1.ifid_rs        = if3.ifid_rs;
  assign if1.ifid_rt        = if3.ifid_rt;
  assign if1.idex_rs        = if3.idex_rs;
  assign if1.idex_rt        = if3.idex_rt;
  assign if1.idex_memread   = if3.idex_memread;
  assign if1.exmem_rd       = if3.exmem_rd;
  assign if1.memwb_rd       = if3.memwb_rd;
  assign if1.exmem_regwrite = if3.exmem_regwrite;
  assign if1.memwb_regwrite = if3.memwb_regwrite;

  hazard_forward_unit #(.REG_AW(AW), .LOAD_STALL(3), .CNT_W(CW)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .hfu   (if3)
  );

  hazard_forward_unit #(.REG_AW(AW), .LOAD_STALL(1), .CNT_W(CW)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .hfu   (if1)
  );

  int tests  = 0;
  int failed = 0;

  // reference model: cycles of stall still owed after the current one, and bubble totals
  int left3 = 0, left1 = 0;
  int cnt3 = 0, cnt1 = 0;
  int seen3 = 0, seen1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input int src, input int exrd, input bit exw,
                                         input int wbrd, input bit wbw);
    if (exw && exrd != 0 && exrd == src) return 2'b10;
    if (wbw && wbrd != 0 && wbrd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_load_use();
    return if3.idex_memread && if3.idex_rt != 0 &&
           (if3.idex_rt == if3.ifid_rs || if3.idex_rt == if3.ifid_rt);
  endfunction

  function automatic bit ref_bubble(input int left);
    return !reset && (left > 0 || ref_load_use());
  endfunction

  task automatic check_now();
    logic [1:0] ea, eb;
    bit b3, b1;
    ea = ref_fwd(if3.idex_rs, if3.exmem_rd, if3.exmem_regwrite, if3.memwb_rd, if3.memwb_regwrite);
    eb = ref_fwd(if3.idex_rt, if3.exmem_rd, if3.exmem_regwrite, if3.memwb_rd, if3.memwb_regwrite);
    b3 = ref_bubble(left3);
    b1 = ref_bubble(left1);
    chk("fwd_a", 32'(if3.forward_a), 32'(ea));
    chk("fwd_b", 32'(if3.forward_b), 32'(eb));
    chk("fwd_a_ls1", 32'(if1.forward_a), 32'(ea));
    chk("bubble_ls3", 32'(if3.idex_bubble), 32'(b3));
    chk("pc_write_ls3", 32'(if3.pc_write), 32'(!b3));
    chk("ifid_write_ls3", 32'(if3.ifid_write), 32'(!b3));
    chk("bubble_ls1", 32'(if1.idex_bubble), 32'(b1));
    chk("pc_write_ls1", 32'(if1.pc_write), 32'(!b1));
`ifdef HFU_STATS_EN
    chk("stall_cnt_ls3", 32'(if3.stall_cnt), 32'(cnt3));
    chk("stall_cnt_ls1", 32'(if1.stall_cnt), 32'(cnt1));
`endif
    if (if3.idex_bubble === 1'b1) seen3++;
    if (if1.idex_bubble === 1'b1) seen1++;
  endtask

  task automatic model_step(inout int left, inout int cnt, input int ls);
    bit b;
    b = ref_bubble(left);
    if (reset) begin
      left = 0;
      cnt  = 0;
    end else begin
      if (b && cnt < (1 << CW) - 1) cnt++;
      if (left > 0) left--;
      else if (ref_load_use()) left = ls - 1;
    end
  endtask

  task automatic cycle();
    #4;
    check_now();
    @(posedge clk);
    model_step(left3, cnt3, 3);
    model_step(left1, cnt1, 1);
    #1;
  endtask

  task automatic set_in(input int exrd, input bit exw, input int wbrd, input bit wbw,
                        input int rs, input int rt);
    if3.exmem_rd       = AW'(exrd);
    if3.exmem_regwrite = exw;
    if3.memwb_rd       = AW'(wbrd);
    if3.memwb_regwrite = wbw;
    if3.idex_rs        = AW'(rs);
    if3.idex_rt        = AW'(rt);
  endtask

  task automatic hazard(input bit on);
    if3.idex_memread = on;
    if3.idex_rt      = 5'd5;
    if3.ifid_rs      = 5'd1;
    if3.ifid_rt      = on ? 5'd5 : 5'd2;
  endtask

  typedef struct {
    int exrd; bit exw; int wbrd; bit wbw; int rs; int rt;
    logic [1:0] ea; logic [1:0] eb;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{3, 1, 3, 1, 3, 0, 2'b10, 2'b00};
    vecs[1] = '{0, 1, 0, 1, 0, 0, 2'b00, 2'b00};
    vecs[2] = '{4, 1, 7, 1, 4, 7, 2'b10, 2'b01};
    vecs[3] = '{5, 0, 5, 1, 5, 5, 2'b01, 2'b01};
    vecs[4] = '{6, 0, 6, 0, 6, 6, 2'b00, 2'b00};
    vecs[5] = '{31, 1, 2, 1, 31, 2, 2'b10, 2'b01};
    vecs[6] = '{9, 1, 9, 0, 1, 9, 2'b00, 2'b10};

    reset = 1'b1;
    if3.idex_memread = 1'b0;
    if3.ifid_rs = '0;
    if3.ifid_rt = '0;
    set_in(0, 0, 0, 0, 0, 0);

    // vectors applied while reset is held: forwarding must not depend on reset
    for (int i = 0; i < 7; i++) begin
      set_in(vecs[i].exrd, vecs[i].exw, vecs[i].wbrd, vecs[i].wbw, vecs[i].rs, vecs[i].rt);
      #2;
      chk($sformatf("vec%0d_fwd_a", i), 32'(if3.forward_a), 32'(vecs[i].ea));
      chk($sformatf("vec%0d_fwd_b", i), 32'(if3.forward_b), 32'(vecs[i].eb));
      cycle();
    end
    chk("reset_pc_write", 32'(if3.pc_write), 32'd1);
    chk("reset_bubble", 32'(if3.idex_bubble), 32'd0);
    set_in(0, 0, 0, 0, 0, 0);

    // one-cycle hazard: LOAD_STALL=1 bubbles once, LOAD_STALL=3 ignores the dropped hazard
    reset = 1'b0;
    seen3 = 0; seen1 = 0;
    hazard(1'b1);
    cycle();
    hazard(1'b0);
    for (int i = 0; i < 5; i++) cycle();
    chk("one_shot_bubbles_ls1", 32'(seen1), 32'd1);
    chk("one_shot_bubbles_ls3", 32'(seen3), 32'd3);
`ifdef HFU_STATS_EN
    chk("one_shot_cnt_ls1", 32'(if1.stall_cnt), 32'd1);
    chk("one_shot_cnt_ls3", 32'(if3.stall_cnt), 32'd3);
`endif

    // hazard held across the whole stall, then released
    reset = 1'b1; cycle(); reset = 1'b0;
    seen3 = 0;
    hazard(1'b1);
    for (int i = 0; i < 3; i++) cycle();
    hazard(1'b0);
    #4;
    chk("held_pc_write_after", 32'(if3.pc_write), 32'd1);
    #1;
    for (int i = 0; i < 3; i++) cycle();
    chk("held_bubbles_ls3", 32'(seen3), 32'd3);
`ifdef HFU_STATS_EN
    chk("held_cnt_ls3", 32'(if3.stall_cnt), 32'd3);
`endif

    // back-to-back: hazard still present in the first IDLE cycle restarts the stall
    reset = 1'b1; cycle(); reset = 1'b0;
    seen3 = 0;
    hazard(1'b1);
    for (int i = 0; i < 4; i++) cycle();
    hazard(1'b0);
    for (int i = 0; i < 5; i++) cycle();
    chk("b2b_bubbles_ls3", 32'(seen3), 32'd6);

    // reset in the second stall cycle aborts the stall
    reset = 1'b1; cycle(); reset = 1'b0;
    hazard(1'b1);
    cycle();
    hazard(1'b0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #4;
    chk("abort_pc_write", 32'(if3.pc_write), 32'd1);
    chk("abort_bubble", 32'(if3.idex_bubble), 32'd0);
`ifdef HFU_STATS_EN
    chk("abort_stall_cnt", 32'(if3.stall_cnt), 32'd0);
`endif
    #1;
    cycle();

    // random traffic against the model; small register space to force matches
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) < 3);
      if3.idex_memread = $urandom_range(0, 1);
      if3.ifid_rs = AW'($urandom_range(0, 3));
      if3.ifid_rt = AW'($urandom_range(0, 3));
      set_in($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
